// File: rtl/instr_program_loader_pkg.sv
// Shared definitions for the instruction program loader and the decode stage.
// Contents:
//   - instruction type codes (TYPE_R/J/I/S)
//   - bit positions of every field inside the 32-bit instruction word
//   - highest legal opcode per instruction type
//   - loader FSM state enum
//   - opcode_legal(): opcode range check used by the packer when the
//     LOADER_OPCODE_CHECK_EN build option is enabled
package instr_program_loader_pkg;

    localparam logic [1:0] TYPE_R = 2'b00;
    localparam logic [1:0] TYPE_J = 2'b01;
    localparam logic [1:0] TYPE_I = 2'b10;
    localparam logic [1:0] TYPE_S = 2'b11;

    localparam int OP_LSB     = 0;
    localparam int RS1_LSB    = 5;
    localparam int RD_LSB     = 10;
    localparam int RS2_LSB    = 15;
    localparam int SA_LSB     = 20;
    localparam int IMM14_LSB  = 15;
    localparam int SIMM24_LSB = 5;
    localparam int TYPE_LSB   = 29;
    localparam int STOP_BIT   = 31;

    localparam logic [4:0] MAX_OP_R = 5'd3;
    localparam logic [4:0] MAX_OP_J = 5'd1;
    localparam logic [4:0] MAX_OP_I = 5'd4;
    localparam logic [4:0] MAX_OP_S = 5'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    // True when the opcode lies inside the legal range of its instruction type.
    function automatic logic opcode_legal(input logic [1:0] typ, input logic [4:0] op);
        logic ok_s;
        case (typ)
            TYPE_R:  ok_s = (op <= MAX_OP_R);
            TYPE_J:  ok_s = (op <= MAX_OP_J);
            TYPE_I:  ok_s = (op <= MAX_OP_I);
            TYPE_S:  ok_s = (op <= MAX_OP_S);
            default: ok_s = 1'b0;
        endcase
        return ok_s;
    endfunction

endpackage

// File: rtl/instr_program_loader_if.sv
// Field-bundle stream into the instruction program loader.
// Signals: in_valid/in_ready handshake, in_type (00=R 01=J 10=I 11=S),
// in_opcode, in_rs1/in_rs2/in_rd, in_imm14, in_simm24, in_sa, in_stop.
// Modports: master = bundle producer (boot host), slave = loader.
interface instr_program_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_type;
    logic [4:0]  in_opcode;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic [4:0]  in_rd;
    logic [13:0] in_imm14;
    logic [23:0] in_simm24;
    logic [4:0]  in_sa;
    logic        in_stop;

    modport master (
        output in_valid, in_type, in_opcode, in_rs1, in_rs2, in_rd,
               in_imm14, in_simm24, in_sa, in_stop,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_type, in_opcode, in_rs1, in_rs2, in_rd,
               in_imm14, in_simm24, in_sa, in_stop,
        output in_ready
    );
endinterface

// File: rtl/instr_program_loader_packer.sv
// instr_field_packer: purely combinational packer from decoded fields to the
// 32-bit instruction word, plus an illegal-opcode flag.
// Inputs : instr_type, opcode, rs1, rs2, rd, imm14, simm24, sa, stop.
// Outputs: word (encoded instruction, unused bits zero), illegal.
// Build option: LOADER_OPCODE_CHECK_EN -- when defined, illegal flags an
// opcode outside its type's range; when undefined, illegal is always 0.
module instr_field_packer
    import instr_program_loader_pkg::*;
(
    input  logic [1:0]  instr_type,
    input  logic [4:0]  opcode,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [13:0] imm14,
    input  logic [23:0] simm24,
    input  logic [4:0]  sa,
    input  logic        stop,
    output logic [31:0] word,
    output logic        illegal
);

    // Field placement: start from zero so bits a type does not use stay clear.
    always_comb begin
        word                 = 32'b0;
        word[STOP_BIT]       = stop;
        word[TYPE_LSB +: 2]  = instr_type;
        word[OP_LSB +: 5]    = opcode;
        case (instr_type)
            TYPE_R: begin
                word[RS1_LSB +: 5] = rs1;
                word[RD_LSB +: 5]  = rd;
                word[RS2_LSB +: 5] = rs2;
            end
            TYPE_J: begin
                word[SIMM24_LSB +: 24] = simm24;
            end
            TYPE_I: begin
                word[RS1_LSB +: 5]    = rs1;
                word[RD_LSB +: 5]     = rd;
                word[IMM14_LSB +: 14] = imm14;
            end
            TYPE_S: begin
                word[RS1_LSB +: 5] = rs1;
                word[RD_LSB +: 5]  = rd;
                word[RS2_LSB +: 5] = rs2;
                word[SA_LSB +: 5]  = sa;
            end
            default: begin
                word = 32'b0;
            end
        endcase
    end

`ifdef LOADER_OPCODE_CHECK_EN
    assign illegal = ~opcode_legal(instr_type, opcode);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/instr_program_loader.sv
// instr_program_loader: accepts decoded field bundles, packs them into 32-bit
// instruction words and writes them to instruction memory from BASE_ADDR.
// Ports:
//   clk, rst (async active-low), start (begin a load in IDLE/DONE/ERR)
//   in_if (slave)  : field-bundle stream, one word per cycle sustained
//   mem_we/mem_addr/mem_wdata : registered write port, one cycle after handshake
//   word_count : words written in the current load
//   busy (LOAD), done (stop word ended the load), err (overflow / illegal op)
// Build option: LOADER_OPCODE_CHECK_EN -- illegal opcodes are handshaken but
// not written and end the load in ERR.
module instr_program_loader
    import instr_program_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    instr_program_loader_if.slave in_if,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   ptr_r, ptr_s;
    logic [ADDR_W:0]     count_r, count_s;
    logic                stop_seen_r, stop_seen_s;
    logic                we_r, we_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [31:0]         wdata_r, wdata_s;
    logic                done_r, done_s;
    logic                err_r, err_s;
    logic                in_ready_s;
    logic                hs_s;
    logic [31:0]         word_s;
    logic                illegal_s;

    instr_field_packer u_packer (
        .instr_type (in_if.in_type),
        .opcode     (in_if.in_opcode),
        .rs1        (in_if.in_rs1),
        .rs2        (in_if.in_rs2),
        .rd         (in_if.in_rd),
        .imm14      (in_if.in_imm14),
        .simm24     (in_if.in_simm24),
        .sa         (in_if.in_sa),
        .stop       (in_if.in_stop),
        .word       (word_s),
        .illegal    (illegal_s)
    );

    // Ready depends only on registered state, so it never combinationally follows in_valid.
    assign in_ready_s     = (state_r == ST_LOAD) && (count_r < DEPTH_C) && !stop_seen_r;
    assign hs_s           = in_if.in_valid && in_ready_s;
    assign in_if.in_ready = in_ready_s;

    assign mem_we     = we_r;
    assign mem_addr   = addr_r;
    assign mem_wdata  = wdata_r;
    assign word_count = count_r;
    assign busy       = (state_r == ST_LOAD);
    assign done       = done_r;
    assign err        = err_r;

    // Next-state and next-output logic; every register holds unless changed below.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        count_s     = count_r;
        stop_seen_s = stop_seen_r;
        we_s        = 1'b0;
        addr_s      = addr_r;
        wdata_s     = wdata_r;
        done_s      = done_r;
        err_s       = err_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_s     = ST_LOAD;
                    ptr_s       = BASE_C;
                    count_s     = '0;
                    stop_seen_s = 1'b0;
                    done_s      = 1'b0;
                    err_s       = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (hs_s) begin
                    if (illegal_s) begin
                        // Consumed but dropped; leaving LOAD now drops ready next cycle.
                        state_s = ST_ERR;
                        err_s   = 1'b1;
                    end else begin
                        we_s        = 1'b1;
                        addr_s      = ptr_r;
                        wdata_s     = word_s;
                        ptr_s       = ptr_r + 1'b1;
                        count_s     = count_r + 1'b1;
                        stop_seen_s = in_if.in_stop;
                    end
                end else if (stop_seen_r) begin
                    // Stop is tested first so a stop in the final slot ends in DONE.
                    state_s = ST_DONE;
                    done_s  = 1'b1;
                end else if (count_r == DEPTH_C) begin
                    state_s = ST_ERR;
                    err_s   = 1'b1;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any pending write at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= BASE_C;
            count_r     <= '0;
            stop_seen_r <= 1'b0;
            we_r        <= 1'b0;
            addr_r      <= BASE_C;
            wdata_r     <= 32'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            count_r     <= count_s;
            stop_seen_r <= stop_seen_s;
            we_r        <= we_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            done_r      <= done_s;
            err_r       <= err_s;
        end
    end

endmodule

// File: tb/tb_instr_program_loader.sv
// Self-checking bench for instr_program_loader: directed steps from the
// encoding examples, overflow and reset cases, then randomized loads checked
// against an arithmetic encoding model.
module tb_instr_program_loader;

    localparam int ADDR_W    = 10;
    localparam int DEPTH     = 4;
    localparam int BASE_ADDR = 0;

    logic              clk   = 1'b0;
    logic              rst   = 1'b0;
    logic              start = 1'b0;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   word_count;
    logic              busy;
    logic              done;
    logic              err;

    int n_err    = 0;
    int n_checks = 0;

    instr_program_loader_if lif ();

    instr_program_loader #(
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE_ADDR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_if      (lif),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .word_count (word_count),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic drive(input logic [1:0] t, input logic [4:0] op, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [13:0] imm,
                         input logic [23:0] simm, input logic [4:0] sa, input logic stop);
        lif.in_type   = t;
        lif.in_opcode = op;
        lif.in_rs1    = rs1;
        lif.in_rs2    = rs2;
        lif.in_rd     = rd;
        lif.in_imm14  = imm;
        lif.in_simm24 = simm;
        lif.in_sa     = sa;
        lif.in_stop   = stop;
    endtask

    task automatic handshake();
        lif.in_valid = 1'b1;
        chk1("ready_before_hs", lif.in_ready, 1'b1);
        step();
        lif.in_valid = 1'b0;
    endtask

    task automatic check_write(input string tag, input int addr, input logic [31:0] data, input int cnt);
        chk1({tag, "_we"}, mem_we, 1'b1);
        chk32({tag, "_addr"}, 32'(mem_addr), 32'(addr));
        chk32({tag, "_data"}, mem_wdata, data);
        chk32({tag, "_count"}, 32'(word_count), 32'(cnt));
    endtask

    // Reference encoding: place each field by multiplying with its bit weight.
    function automatic logic [31:0] ref_word(input int unsigned t, input int unsigned op,
                                             input int unsigned rs1, input int unsigned rs2,
                                             input int unsigned rd, input int unsigned imm,
                                             input int unsigned simm, input int unsigned sa,
                                             input int unsigned stop);
        longint unsigned w;
        w = longint'(stop) * 64'd2147483648 + longint'(t) * 64'd536870912 + longint'(op);
        if (t == 0)      w += longint'(rs1) * 32 + longint'(rd) * 1024 + longint'(rs2) * 32768;
        else if (t == 1) w += longint'(simm) * 32;
        else if (t == 2) w += longint'(rs1) * 32 + longint'(rd) * 1024 + longint'(imm) * 32768;
        else             w += longint'(rs1) * 32 + longint'(rd) * 1024 + longint'(rs2) * 32768
                              + longint'(sa) * 1048576;
        return w[31:0];
    endfunction

    function automatic int unsigned max_op(input int unsigned t);
        if (t == 0)      return 3;
        else if (t == 1) return 1;
        else if (t == 2) return 4;
        else             return 3;
    endfunction

    function automatic int exp_addr(input int idx);
        return (BASE_ADDR + idx) % (1 << ADDR_W);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned t, op, rs1, rs2, rd, imm, simm, sa, stp;
        int len;

        lif.in_valid = 1'b0;
        drive(2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 14'd0, 24'd0, 5'd0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_ready", lif.in_ready, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_err", err, 1'b0);
        chk32("rst_addr", 32'(mem_addr), 32'(BASE_ADDR));
        chk32("rst_wdata", mem_wdata, 32'h0);
        chk32("rst_count", 32'(word_count), 32'd0);
        rst = 1'b1;
        step();
        chk1("idle_no_start", busy, 1'b0);

        // Load A: R, J, S then stop word landing exactly in the last slot
        pulse_start();
        chk1("a_busy", busy, 1'b1);
        chk1("a_ready", lif.in_ready, 1'b1);
        chk32("a_count0", 32'(word_count), 32'd0);
        drive(2'b00, 5'd0, 5'd1, 5'd2, 5'd3, 14'h3FFF, 24'hFFFFFF, 5'h1F, 1'b0);
        handshake();
        check_write("r_add", 0, 32'h0001_0C20, 1);
        step();
        chk1("gap_we", mem_we, 1'b0);
        pulse_start();
        chk32("start_in_load_count", 32'(word_count), 32'd1);
        chk1("start_in_load_busy", busy, 1'b1);
        drive(2'b01, 5'd1, 5'h1F, 5'h1F, 5'h1F, 14'h3FFF, 24'hFFFFFF, 5'h1F, 1'b0);
        handshake();
        check_write("j_op1", 1, 32'h3FFF_FFE1, 2);
        drive(2'b11, 5'd3, 5'd1, 5'd3, 5'd2, 14'h3FFF, 24'hFFFFFF, 5'd31, 1'b0);
        handshake();
        check_write("s_op3", 2, 32'h61F1_8823, 3);
        drive(2'b10, 5'd4, 5'd2, 5'h1F, 5'd5, 14'h3FFF, 24'hFFFFFF, 5'h1F, 1'b1);
        handshake();
        check_write("i_stop_last", 3, 32'hDFFF_9444, 4);
        chk1("a_ready_after_last", lif.in_ready, 1'b0);
        step();
        chk1("a_done", done, 1'b1);
        chk1("a_err_not_set", err, 1'b0);
        chk1("a_busy_end", busy, 1'b0);
        chk1("a_we_end", mem_we, 1'b0);

        // Load B: single stop word
        pulse_start();
        chk32("b_count0", 32'(word_count), 32'd0);
        chk1("b_done_cleared", done, 1'b0);
        drive(2'b10, 5'd4, 5'd2, 5'd0, 5'd5, 14'h3FFF, 24'd0, 5'd0, 1'b1);
        handshake();
        check_write("i_stop", 0, 32'hDFFF_9444, 1);
        chk1("b_ready_drop", lif.in_ready, 1'b0);
        step();
        chk1("b_done", done, 1'b1);
        chk1("b_busy", busy, 1'b0);
        chk1("b_ready", lif.in_ready, 1'b0);
        chk32("b_count", 32'(word_count), 32'd1);

        // Load C: overflow with five back-to-back bundles and no stop
        pulse_start();
        lif.in_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive(2'b00, 5'd0, 5'd0, 5'd0, 5'(i), 14'd0, 24'd0, 5'd0, 1'b0);
            chk1("ovf_ready", lif.in_ready, 1'b1);
            step();
            check_write("ovf", exp_addr(i), ref_word(0, 0, 0, 0, i, 0, 0, 0, 0), i + 1);
        end
        drive(2'b00, 5'd0, 5'd0, 5'd0, 5'd9, 14'd0, 24'd0, 5'd0, 1'b0);
        chk1("ovf_ready_full", lif.in_ready, 1'b0);
        step();
        chk1("ovf_no_fifth_we", mem_we, 1'b0);
        chk1("ovf_err", err, 1'b1);
        chk1("ovf_done", done, 1'b0);
        chk1("ovf_ready_err", lif.in_ready, 1'b0);
        lif.in_valid = 1'b0;
        pulse_start();
        chk32("rearm_count", 32'(word_count), 32'd0);
        chk1("rearm_err", err, 1'b0);
        chk1("rearm_busy", busy, 1'b1);

        // J with out-of-range opcode
        drive(2'b01, 5'd2, 5'd0, 5'd0, 5'd0, 14'd0, 24'd0, 5'd0, 1'b0);
        handshake();
`ifdef LOADER_OPCODE_CHECK_EN
        chk1("illop_we", mem_we, 1'b0);
        chk1("illop_err", err, 1'b1);
        chk1("illop_ready", lif.in_ready, 1'b0);
        chk32("illop_count", 32'(word_count), 32'd0);
`else
        check_write("j_op2", 0, 32'h2000_0002, 1);
`endif
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step();

        // Randomized loads against the reference encoding
        for (int l = 0; l < 6; l++) begin
            pulse_start();
            len = int'($urandom_range(1, DEPTH));
            lif.in_valid = 1'b1;
            for (int i = 0; i < len; i++) begin
                t    = $urandom_range(0, 3);
                op   = $urandom_range(0, max_op(t));
                rs1  = $urandom_range(0, 31);
                rs2  = $urandom_range(0, 31);
                rd   = $urandom_range(0, 31);
                imm  = $urandom_range(0, 16383);
                simm = $urandom_range(0, 24'hFFFFFF);
                sa   = $urandom_range(0, 31);
                stp  = (i == len - 1) ? 1 : 0;
                drive(2'(t), 5'(op), 5'(rs1), 5'(rs2), 5'(rd), 14'(imm), 24'(simm), 5'(sa), 1'(stp));
                chk1("rnd_ready", lif.in_ready, 1'b1);
                step();
                check_write("rnd", exp_addr(i), ref_word(t, op, rs1, rs2, rd, imm, simm, sa, stp), i + 1);
            end
            lif.in_valid = 1'b0;
            chk1("rnd_ready_after_stop", lif.in_ready, 1'b0);
            step();
            chk1("rnd_done", done, 1'b1);
            chk1("rnd_busy", busy, 1'b0);
        end

        // Reset in the middle of a stream while in_valid stays high
        pulse_start();
        drive(2'b00, 5'd1, 5'd4, 5'd5, 5'd6, 14'd0, 24'd0, 5'd0, 1'b0);
        lif.in_valid = 1'b1;
        step();
        chk1("pre_rst_we", mem_we, 1'b1);
        rst = 1'b0;
        #1;
        chk1("rst_mid_we", mem_we, 1'b0);
        chk1("rst_mid_busy", busy, 1'b0);
        chk1("rst_mid_ready", lif.in_ready, 1'b0);
        chk32("rst_mid_count", 32'(word_count), 32'd0);
        #2;
        rst = 1'b1;
        step();
        chk1("post_rst_idle", busy, 1'b0);
        chk1("post_rst_we", mem_we, 1'b0);
        lif.in_valid = 1'b0;
        pulse_start();
        drive(2'b00, 5'd0, 5'd1, 5'd2, 5'd3, 14'd0, 24'd0, 5'd0, 1'b0);
        handshake();
        check_write("post_rst_write", BASE_ADDR, 32'h0001_0C20, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_program_loader.md
Name: instr_program_loader

Overview:
- Producer end of the 32-bit instruction format that the decode stage consumes.
- Accepts decoded instruction fields over a valid/ready stream and packs them into 32-bit words with the same bit layout.
- Writes the words sequentially into instruction memory, from a base address.
- Sits between the testbench/boot host and instruction memory; it fills memory before the fetch/decode pipeline is released.

Parameters:
- ADDR_W, 10, instruction-memory word-address width.
- DEPTH, 1024, maximum number of words in one program load; must be ≤ 2^ADDR_W.
- BASE_ADDR, 0, word address of the first instruction written.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin a new load; honoured in IDLE, DONE or ERR.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- in_type  in  2  00=R, 01=J, 10=I, 11=S.
- in_opcode  in  5  opcode field.
- in_rs1, in_rs2, in_rd  in  5 each  register specifiers.
- in_imm14  in  14  I-type immediate.
- in_simm24  in  24  J-type signed immediate.
- in_sa  in  5  S-type shift amount.
- in_stop  in  1  last instruction of the program; becomes bit 31.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded instruction.
- word_count  out  ADDR_W+1  words written in the current load.
- busy  out  1  state is LOAD.
- done  out  1  level; last load terminated by a stop word.
- err  out  1  level; last load overflowed DEPTH or hit an illegal opcode.

Behaviour:
- Encoding (bits 31..0), unused bits forced to 0 and fields not used by the type ignored:
  - R = {stop, 00, 9'b0, rs2, rd, rs1, op}
  - J = {stop, 01, simm24, op}
  - I = {stop, 10, imm14, rd, rs1, op}
  - S = {stop, 11, 4'b0, sa, rs2, rd, rs1, op}
- Reset: state IDLE; in_ready, mem_we, busy, done, err = 0; mem_addr = BASE_ADDR; mem_wdata = 0; word_count = 0.
- FSM IDLE/LOAD/DONE/ERR:
  - start in IDLE, DONE or ERR → LOAD. Clears word_count, done and err; write pointer = BASE_ADDR.
  - start while in LOAD is ignored.
- in_ready = (state == LOAD) && (word_count < DEPTH) && !stop_seen.
  - A handshake occurs when in_valid && in_ready.
- Latency: one cycle. The handshake at edge N drives mem_we = 1, mem_addr and mem_wdata for exactly the cycle after N. The pointer and word_count increment at that same edge.
- Back-to-back: one word per cycle sustained. mem_we = 0 on cycles with no handshake.
- Stop word: when the accepted bundle has in_stop = 1, in_ready drops the next cycle. After the write cycle the state goes to DONE and done = 1.
- Overflow: if word DEPTH-1 is accepted without stop, it is written, then the state goes to ERR with err = 1.
  - If that last word carries stop, DONE takes priority.
- Address arithmetic: mem_addr = BASE_ADDR + index, modulo 2^ADDR_W (wraps silently).
- Reset mid-load: any pending write is dropped (mem_we = 0 immediately). Memory contents already written are untouched.

Optional Feature:
- Macro LOADER_OPCODE_CHECK_EN.
- Defined: the bundle's opcode is checked against the legal range for its type: R 0–3, I 0–4, J 0–1, S 0–3.
  - An illegal opcode is still handshaken but not written.
  - State goes to ERR, err = 1, in_ready drops the next cycle.
- Undefined: every opcode is encoded and written unchecked.

Decomposition:
- Shared package holds:
  - type codes TYPE_R/J/I/S.
  - field bit positions (OP_LSB 0, RS1_LSB 5, RD_LSB 10, RS2_LSB 15, SA_LSB 20, IMM14_LSB 15, SIMM24_LSB 5, TYPE_LSB 29, STOP_BIT 31).
  - per-type max opcode constants.
  - the FSM state enum.
- One natural sub-module, instr_field_packer: a purely combinational packer (fields → 32-bit word) plus the illegal-opcode flag. The decode stage's unit tests reuse it.

Test Plan:
- R add r3 = r1 + r2, op 0, stop 0 → mem_wdata 0x0001_0C20, mem_addr 0, mem_we one cycle after handshake.
- I op 4, rs1 2, rd 5, imm14 0x3FFF, stop 1 → 0xDFFF_9444 written. Then done = 1, busy = 0, in_ready = 0, word_count = 1.
- J op 1, simm24 0xFFFFFF → 0x3FFF_FFE1. S op 3, rs1 1, rd 2, rs2 3, sa 31, unused inputs all 1s → 0x61F1_8823 (unused bits zero).
- DEPTH = 4, five valid bundles without stop → four writes at addresses 0–3, then err = 1 and in_ready = 0. start then re-arms with word_count = 0.
- With LOADER_OPCODE_CHECK_EN, a J bundle with op 2 → no mem_we, err = 1. Without the macro → 0x2000_0002 is written.
- rst low mid-stream while in_valid = 1 → mem_we = 0 immediately, state IDLE. start then rewrites from BASE_ADDR.
